// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM behind the AHB slave memory port; writes complete on acceptance.
// Reads return RD_LAT cycles after acceptance; o_ready is held low while a read is outstanding.
module ahb_sram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 2
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0] req_idx;
    logic             req_oor;
    logic             accept;
    logic             wr_en;
    logic             unused_addr_lsbs;

    // Byte lane bits are ignored; anything above the array span flags out-of-range.
    assign req_idx          = i_addr[IDX_W+1:2];
    assign req_oor          = |i_addr[ADDR_WIDTH-1:IDX_W+2];
    assign unused_addr_lsbs = ^i_addr[1:0];

    assign o_ready    = (state_q == IDLE);
    assign accept     = i_valid && o_ready;
    assign wr_en      = accept && i_rd0_wr1 && !req_oor;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_err      = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oor_d      = oor_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_rd0_wr1) begin
                        err_d = req_oor;
                    end else begin
                        idx_d   = req_idx;
                        oor_d   = req_oor;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Array is sampled only at completion, so earlier writes are always visible.
                if (cnt_q == '0) begin
                    rd_valid_d = 1'b1;
                    err_d      = oor_q;
                    rd_data_d  = oor_q ? '0 : mem_q[idx_q];
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            oor_q      <= oor_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately unreset so contents survive a reset pulse.
    always_ff @(posedge i_clk_ahb) begin
        if (wr_en) begin
            mem_q[req_idx] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_ahb_sram_mem.sv
// Self-checking bench for ahb_sram_mem: directed scenarios plus randomized traffic
// compared against an array-based memory model.
module tb_ahb_sram_mem;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          valid = 1'b0;
    logic          rw    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model   [DEPTH];
    bit            written [DEPTH];

    ahb_sram_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .i_clk_ahb (clk),
        .i_rstn_ahb(rstn),
        .i_valid   (valid),
        .i_rd0_wr1 (rw),
        .i_addr    (addr),
        .i_wr_data (wdata),
        .o_ready   (ready),
        .o_rd_valid(rd_valid),
        .o_rd_data (rd_data),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    function automatic bit is_oor(logic [AW-1:0] a);
        return (a >> 2) >= DEPTH;
    endfunction

    function automatic int idx_of(logic [AW-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout got ready=%0b exp 1", ready);
        end
    endtask

    task automatic idle_bus();
        valid = 1'b0;
        rw    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Write stays on the bus after its edge; caller replaces it or idles the bus.
    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit e);
        wait_ready();
        valid = 1'b1;
        rw    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        e = err;
        if (!is_oor(a)) begin
            model[idx_of(a)]   = d;
            written[idx_of(a)] = 1'b1;
        end
    endtask

    // Returns at the negedge inside the rd_valid pulse; lat counts edges after acceptance.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] data, output bit e,
                           output int lat, output int rdy_low, output bit rdy_at_done);
        data        = '0;
        e           = 1'b0;
        lat         = -1;
        rdy_low     = 0;
        rdy_at_done = 1'b0;
        wait_ready();
        valid = 1'b1;
        rw    = 1'b0;
        addr  = a;
        @(negedge clk);
        idle_bus();
        for (int k = 0; k <= 40; k++) begin
            if (rd_valid) begin
                lat         = k;
                data        = rd_data;
                e           = err;
                rdy_at_done = ready;
                break;
            end
            if (!ready) rdy_low++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== '0)    begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        bit e, rdone;
        int lat, rlow;
        drive_write(32'h10, 32'hA5A5_0001, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
        do_read(32'h10, d, e, lat, rlow, rdone);
        checks++; if (lat != RD_LAT)       begin errors++; $display("FAIL rd_latency got %0d exp %0d", lat, RD_LAT); end
        checks++; if (rlow != RD_LAT)      begin errors++; $display("FAIL rd_ready_low got %0d exp %0d", rlow, RD_LAT); end
        checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data got %h exp a5a50001", d); end
        checks++; if (rdone !== 1'b1)      begin errors++; $display("FAIL rd_ready_at_done got %b exp 1", rdone); end
        checks++; if (e !== 1'b0)          begin errors++; $display("FAIL rd_err got %b exp 0", e); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0)        begin errors++; $display("FAIL rd_pulse_width got %b exp 0", rd_valid); end
        checks++; if (rd_data !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data_hold got %h exp a5a50001", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        bit e, rdone;
        int lat, rlow;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_stall[%0d] got %b exp 1", i, ready); end
            drive_write(AW'(i * 4), DW'(i + 1), e);
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL b2b_wr_err[%0d] got %b exp 0", i, e); end
        end
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(i * 4), d, e, lat, rlow, rdone);
            checks++; if (d !== DW'(i + 1)) begin errors++; $display("FAIL b2b_rd_data[%0d] got %h exp %h", i, d, DW'(i + 1)); end
            checks++; if (rlow != RD_LAT)   begin errors++; $display("FAIL b2b_rd_stall[%0d] got %0d exp %0d", i, rlow, RD_LAT); end
            checks++; if (lat != RD_LAT)    begin errors++; $display("FAIL b2b_rd_lat[%0d] got %0d exp %0d", i, lat, RD_LAT); end
        end
    endtask

    task automatic test_hold_during_wait();
        logic [DW-1:0] oldd, newd, d;
        bit e, rdone;
        int lat, rlow, k;
        oldd = $urandom;
        newd = ~oldd;
        drive_write(32'h20, oldd, e);
        idle_bus();
        wait_ready();
        valid = 1'b1; rw = 1'b0; addr = 32'h20;
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h20; wdata = newd;
        k = 0;
        while (!rd_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k != RD_LAT)      begin errors++; $display("FAIL hold_rd_lat got %0d exp %0d", k, RD_LAT); end
        checks++; if (rd_data !== oldd) begin errors++; $display("FAIL hold_early_write got %h exp %h", rd_data, oldd); end
        checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL hold_ready_at_done got %b exp 1", ready); end
        @(negedge clk);
        model[idx_of(32'h20)] = newd;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_wr_err got %b exp 0", err); end
        idle_bus();
        do_read(32'h20, d, e, lat, rlow, rdone);
        checks++; if (d !== newd) begin errors++; $display("FAIL hold_wr_applied got %h exp %h", d, newd); end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        bit e, rdone;
        int lat, rlow;
        drive_write(32'h400, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", e); end
        idle_bus();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_wr_err_width got %b exp 0", err); end
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(i * 4), d, e, lat, rlow, rdone);
            checks++; if (d !== model[i]) begin errors++; $display("FAIL oor_alias[%0d] got %h exp %h", i, d, model[i]); end
        end
        do_read(32'h400, d, e, lat, rlow, rdone);
        checks++; if (d !== '0)       begin errors++; $display("FAIL oor_rd_data got %h exp 0", d); end
        checks++; if (e !== 1'b1)     begin errors++; $display("FAIL oor_rd_err got %b exp 1", e); end
        checks++; if (lat != RD_LAT)  begin errors++; $display("FAIL oor_rd_lat got %0d exp %0d", lat, RD_LAT); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_rd_err_width got %b exp 0", err); end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] d;
        bit e, rdone;
        int lat, rlow, stray;
        wait_ready();
        valid = 1'b1; rw = 1'b0; addr = 32'h10;
        @(negedge clk);
        idle_bus();
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL rst_mid_ready got %b exp 1", ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_valid got %b exp 0", rd_valid); end
        @(negedge clk);
        rstn = 1'b1;
        stray = 0;
        for (int i = 0; i < RD_LAT + 4; i++) begin
            @(negedge clk);
            if (rd_valid) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_stray_rd_valid got %0d exp 0", stray); end
        do_read(32'h10, d, e, lat, rlow, rdone);
        checks++; if (d !== model[idx_of(32'h10)]) begin errors++; $display("FAIL rst_retain_10 got %h exp %h", d, model[idx_of(32'h10)]); end
        do_read(32'h8, d, e, lat, rlow, rdone);
        checks++; if (d !== model[idx_of(32'h8)]) begin errors++; $display("FAIL rst_retain_8 got %h exp %h", d, model[idx_of(32'h8)]); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit e, rdone;
        int lat, rlow;
        for (int n = 0; n < 300; n++) begin
            a = AW'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (AW'($urandom_range(1, 255)) << 10);
            if ($urandom_range(0, 1) == 1) begin
                drive_write(a, $urandom, e);
                checks++; if (e !== is_oor(a)) begin errors++; $display("FAIL rnd_wr_err a=%h got %b exp %b", a, e, is_oor(a)); end
                if ($urandom_range(0, 1) == 1) idle_bus();
            end else begin
                do_read(a, d, e, lat, rlow, rdone);
                checks++; if (lat != RD_LAT)   begin errors++; $display("FAIL rnd_rd_lat a=%h got %0d exp %0d", a, lat, RD_LAT); end
                checks++; if (e !== is_oor(a)) begin errors++; $display("FAIL rnd_rd_err a=%h got %b exp %b", a, e, is_oor(a)); end
                if (is_oor(a)) begin
                    checks++; if (d !== '0) begin errors++; $display("FAIL rnd_rd_oor_data a=%h got %h exp 0", a, d); end
                end else if (written[idx_of(a)]) begin
                    checks++; if (d !== model[idx_of(a)]) begin errors++; $display("FAIL rnd_rd_data a=%h got %h exp %h", a, d, model[idx_of(a)]); end
                end
            end
        end
        idle_bus();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_hold_during_wait();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
